// File: rtl/axis_mm_controller.sv
// ---------------------------------------------------------------------------
// axis_mm_controller
//
// Top-level sequencer for the AXI-Stream matrix-multiply coprocessor.
//   1. Accepts A then B operand words on the slave stream and writes them
//      into A_RAM / B_RAM through registered write ports.
//   2. Pulses Start to matrix_multiply and waits for its Done pulse.
//   3. Reads RES_RAM 0..RES_WORDS-1 and streams it out on the master stream
//      through a 2-entry prefetch buffer.
//
// Ports:
//   ACLK, ARESET                      clock, synchronous active-high reset
//   S_AXIS_*                          operand input stream (slave)
//   M_AXIS_*                          result output stream (master)
//   A_write_* / B_write_*             operand RAM write ports (1-cycle pulse)
//   Start / Done                      handshake with matrix_multiply
//   RES_read_en / RES_read_address    result RAM read request
//   RES_read_data_out                 result RAM data, 1 cycle after read_en
//   Protocol_error                    sticky TLAST framing error flag
//
// Optional feature: define INPUT_TLAST_CHECK_EN to validate S_AXIS_TLAST
// against the word count. Without it TLAST is ignored and Protocol_error
// is tied low.
// ---------------------------------------------------------------------------
module axis_mm_controller #(
    parameter int width          = 8,
    parameter int A_depth_bits   = 9,
    parameter int B_depth_bits   = 3,
    parameter int RES_depth_bits = 6
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    output logic                      S_AXIS_TREADY,
    input  logic [31:0]               S_AXIS_TDATA,
    input  logic                      S_AXIS_TLAST,
    input  logic                      S_AXIS_TVALID,
    output logic                      M_AXIS_TVALID,
    output logic [31:0]               M_AXIS_TDATA,
    output logic                      M_AXIS_TLAST,
    input  logic                      M_AXIS_TREADY,
    output logic                      A_write_en,
    output logic [A_depth_bits-1:0]   A_write_address,
    output logic [width-1:0]          A_write_data_in,
    output logic                      B_write_en,
    output logic [B_depth_bits-1:0]   B_write_address,
    output logic [width-1:0]          B_write_data_in,
    output logic                      Start,
    input  logic                      Done,
    output logic                      RES_read_en,
    output logic [RES_depth_bits-1:0] RES_read_address,
    input  logic [width-1:0]          RES_read_data_out,
    output logic                      Protocol_error
);

    localparam int A_WORDS   = 1 << A_depth_bits;
    localparam int B_WORDS   = 1 << B_depth_bits;
    localparam int IN_WORDS  = A_WORDS + B_WORDS;
    localparam int RES_WORDS = 1 << RES_depth_bits;
    localparam int CNT_W     = $clog2(IN_WORDS);
    localparam int RD_W      = RES_depth_bits + 1;

    localparam logic [CNT_W-1:0]          LAST_IN   = CNT_W'(IN_WORDS - 1);
    localparam logic [CNT_W-1:0]          A_LIMIT   = CNT_W'(A_WORDS);
    localparam logic [RD_W-1:0]           RES_COUNT = RD_W'(RES_WORDS);
    localparam logic [RES_depth_bits-1:0] LAST_OUT  = RES_depth_bits'(RES_WORDS - 1);

    typedef enum logic [1:0] {
        READ_INPUTS,
        COMPUTE,
        WRITE_OUTPUTS
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]          inCount_q, inCount_d;
    logic                      aWe_q, aWe_d, bWe_q, bWe_d;
    logic [A_depth_bits-1:0]   aAddr_q, aAddr_d;
    logic [B_depth_bits-1:0]   bAddr_q, bAddr_d;
    logic [width-1:0]          wrData_q, wrData_d;
    logic                      start_q, start_d;

    logic [RD_W-1:0]           rdAddr_q, rdAddr_d;
    logic                      pending_q, pending_d;
    logic [1:0]                bufCount_q, bufCount_d;
    logic [width-1:0]          buf0_q, buf0_d, buf1_q, buf1_d;
    logic [RES_depth_bits-1:0] outCount_q, outCount_d;

    logic             inHs, lastWord, frameError;
    logic             readEn, outValid, outHs, push, pop, lastOut;
    logic [width-1:0] headData;

    assign inHs     = S_AXIS_TVALID && (state_q == READ_INPUTS);
    assign lastWord = (inCount_q == LAST_IN);

`ifdef INPUT_TLAST_CHECK_EN
    logic protoErr_q, protoErr_d;
    logic unusedInputs;

    // A frame is bad when TLAST disagrees with the word count, either early or missing.
    assign frameError     = inHs && (S_AXIS_TLAST != lastWord);
    assign protoErr_d     = protoErr_q || frameError;
    assign Protocol_error = protoErr_q;
    assign unusedInputs   = ^S_AXIS_TDATA[31:width];
`else
    logic unusedInputs;

    assign frameError     = 1'b0;
    assign Protocol_error = 1'b0;
    assign unusedInputs   = ^{S_AXIS_TDATA[31:width], S_AXIS_TLAST};
`endif

    // Output buffer occupancy: up to two stored words plus one read in flight.
    // When the buffer is empty the returning RAM word is presented directly,
    // which keeps the Done-to-TVALID latency at two cycles.
    assign outValid = (bufCount_q != 2'd0) || pending_q;
    assign headData = (bufCount_q != 2'd0) ? buf0_q : RES_read_data_out;
    assign outHs    = outValid && M_AXIS_TREADY;
    assign lastOut  = (outCount_q == LAST_OUT);
    assign pop      = outHs && (bufCount_q != 2'd0);
    assign push     = pending_q && !(outHs && (bufCount_q == 2'd0));

    // A read is only issued if the word it returns is guaranteed a slot.
    assign readEn = (state_q == WRITE_OUTPUTS) && (rdAddr_q < RES_COUNT) &&
                    ((bufCount_q == 2'd0) || ((bufCount_q == 2'd1) && !pending_q));

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= READ_INPUTS;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Done is ignored in the Start cycle and outside COMPUTE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            READ_INPUTS:   if (inHs && lastWord && !frameError) state_d = COMPUTE;
            COMPUTE:       if (Done && !start_q) state_d = WRITE_OUTPUTS;
            WRITE_OUTPUTS: if (outHs && lastOut) state_d = READ_INPUTS;
            default:       state_d = READ_INPUTS;
        endcase
    end

    // Output logic: input-side write pulses and Start are computed here and
    // registered below so they appear the cycle after the handshake.
    always_comb begin
        aWe_d     = 1'b0;
        bWe_d     = 1'b0;
        aAddr_d   = aAddr_q;
        bAddr_d   = bAddr_q;
        wrData_d  = wrData_q;
        inCount_d = inCount_q;
        start_d   = 1'b0;
        if (inHs) begin
            wrData_d = S_AXIS_TDATA[width-1:0];
            if (inCount_q < A_LIMIT) begin
                aWe_d   = 1'b1;
                aAddr_d = inCount_q[A_depth_bits-1:0];
            end else begin
                bWe_d   = 1'b1;
                bAddr_d = B_depth_bits'(inCount_q - A_LIMIT);
            end
            if (lastWord || frameError) begin
                inCount_d = '0;
            end else begin
                inCount_d = inCount_q + CNT_W'(1);
            end
            start_d = lastWord && !frameError;
        end
    end

    // Prefetch buffer as a two-deep shift register; slot 0 is always the head.
    always_comb begin
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        bufCount_d = bufCount_q;
        case ({push, pop})
            2'b10: begin
                if (bufCount_q == 2'd0) buf0_d = RES_read_data_out;
                else                    buf1_d = RES_read_data_out;
                bufCount_d = bufCount_q + 2'd1;
            end
            2'b01: begin
                buf0_d     = buf1_q;
                bufCount_d = bufCount_q - 2'd1;
            end
            2'b11: begin
                if (bufCount_q == 2'd1) begin
                    buf0_d = RES_read_data_out;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = RES_read_data_out;
                end
            end
            default: ;
        endcase
        pending_d = readEn;
        if (outHs && lastOut) begin
            rdAddr_d   = '0;
            outCount_d = '0;
        end else begin
            rdAddr_d   = rdAddr_q + RD_W'(readEn);
            outCount_d = outCount_q + RES_depth_bits'(outHs);
        end
    end

    // Datapath registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            inCount_q  <= '0;
            aWe_q      <= 1'b0;
            bWe_q      <= 1'b0;
            aAddr_q    <= '0;
            bAddr_q    <= '0;
            wrData_q   <= '0;
            start_q    <= 1'b0;
            rdAddr_q   <= '0;
            pending_q  <= 1'b0;
            bufCount_q <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            outCount_q <= '0;
`ifdef INPUT_TLAST_CHECK_EN
            protoErr_q <= 1'b0;
`endif
        end else begin
            inCount_q  <= inCount_d;
            aWe_q      <= aWe_d;
            bWe_q      <= bWe_d;
            aAddr_q    <= aAddr_d;
            bAddr_q    <= bAddr_d;
            wrData_q   <= wrData_d;
            start_q    <= start_d;
            rdAddr_q   <= rdAddr_d;
            pending_q  <= pending_d;
            bufCount_q <= bufCount_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            outCount_q <= outCount_d;
`ifdef INPUT_TLAST_CHECK_EN
            protoErr_q <= protoErr_d;
`endif
        end
    end

    assign S_AXIS_TREADY    = (state_q == READ_INPUTS);
    assign A_write_en       = aWe_q;
    assign A_write_address  = aAddr_q;
    assign A_write_data_in  = wrData_q;
    assign B_write_en       = bWe_q;
    assign B_write_address  = bAddr_q;
    assign B_write_data_in  = wrData_q;
    assign Start            = start_q;
    assign RES_read_en      = readEn;
    assign RES_read_address = rdAddr_q[RES_depth_bits-1:0];
    assign M_AXIS_TVALID    = outValid;
    assign M_AXIS_TDATA     = outValid ? {{(32-width){1'b0}}, headData} : 32'd0;
    assign M_AXIS_TLAST     = outValid && lastOut;

endmodule

// File: tb/tb_axis_mm_controller.sv
// ---------------------------------------------------------------------------
// tb_axis_mm_controller
//
// Scoreboard bench: stimulus pushes expected RAM writes and expected output
// words into queues; independent monitors pop and compare whenever the DUT
// presents a write pulse or a master-stream handshake. A small Done model
// answers Start after 10 cycles, and RES_RAM is modelled as an array with
// a one-cycle synchronous read.
// ---------------------------------------------------------------------------
module tb_axis_mm_controller;

    localparam int W         = 8;
    localparam int AW        = 9;
    localparam int BW        = 3;
    localparam int RW        = 6;
    localparam int A_WORDS   = 512;
    localparam int IN_WORDS  = 520;
    localparam int RES_WORDS = 64;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          S_AXIS_TREADY;
    logic [31:0]   S_AXIS_TDATA;
    logic          S_AXIS_TLAST;
    logic          S_AXIS_TVALID;
    logic          M_AXIS_TVALID;
    logic [31:0]   M_AXIS_TDATA;
    logic          M_AXIS_TLAST;
    logic          M_AXIS_TREADY;
    logic          A_write_en;
    logic [AW-1:0] A_write_address;
    logic [W-1:0]  A_write_data_in;
    logic          B_write_en;
    logic [BW-1:0] B_write_address;
    logic [W-1:0]  B_write_data_in;
    logic          Start;
    logic          Done;
    logic          RES_read_en;
    logic [RW-1:0] RES_read_address;
    logic [W-1:0]  RES_read_data_out;
    logic          Protocol_error;

    logic doneModel;
    logic doneSpur;
    assign Done = doneModel | doneSpur;

    always #5 ACLK = ~ACLK;

    axis_mm_controller dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TDATA(S_AXIS_TDATA),
        .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA),
        .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
        .A_write_en(A_write_en), .A_write_address(A_write_address),
        .A_write_data_in(A_write_data_in),
        .B_write_en(B_write_en), .B_write_address(B_write_address),
        .B_write_data_in(B_write_data_in),
        .Start(Start), .Done(Done),
        .RES_read_en(RES_read_en), .RES_read_address(RES_read_address),
        .RES_read_data_out(RES_read_data_out),
        .Protocol_error(Protocol_error)
    );

    // RES_RAM model: synchronous read, data one cycle after read_en.
    logic [W-1:0] resRam [RES_WORDS];
    always @(posedge ACLK) begin
        if (RES_read_en) RES_read_data_out <= resRam[RES_read_address];
    end

    typedef struct packed {
        logic          isA;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wr_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
        logic [6:0]   idx;
    } out_t;

    wr_t  wrQ[$];
    out_t expQ[$];

    int numChecks = 0;
    int numErrors = 0;
    int startCount = 0;
    int wordsOut = 0;
    int cyc = 0;
    int readyMode = 0;
    bit ignoreWrites = 0;
    bit rstFlag = 0;
    bit checkConsec = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic failNow(input string name);
        numChecks++;
        numErrors++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endtask

    initial forever begin
        @(posedge ACLK);
        cyc++;
    end

    // Master-side TREADY driver: always ready, fixed 1,0,0,1,0,1 pattern, or random.
    initial begin
        int pIdx;
        bit readyPat [6];
        readyPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        pIdx = 0;
        M_AXIS_TREADY = 1'b1;
        forever begin
            @(posedge ACLK);
            #1;
            case (readyMode)
                1: begin
                    M_AXIS_TREADY = readyPat[pIdx];
                    pIdx = (pIdx + 1) % 6;
                end
                2:       M_AXIS_TREADY = 1'($urandom_range(0, 1));
                default: M_AXIS_TREADY = 1'b1;
            endcase
        end
    end

    // Write-port monitor.
    initial begin
        wr_t e;
        forever begin
            @(negedge ACLK);
            if ((A_write_en === 1'b1 || B_write_en === 1'b1) && !ignoreWrites) begin
                if (wrQ.size() == 0) begin
                    failNow("unexpected RAM write");
                end else begin
                    e = wrQ.pop_front();
                    checkOutput("write port select", 32'(A_write_en), 32'(e.isA));
                    checkOutput("write single port", 32'(A_write_en && B_write_en), 32'd0);
                    if (e.isA) begin
                        checkOutput("A write address", 32'(A_write_address), 32'(e.addr));
                        checkOutput("A write data", 32'(A_write_data_in), 32'(e.data));
                    end else begin
                        checkOutput("B write address", 32'(B_write_address), 32'(e.addr));
                        checkOutput("B write data", 32'(B_write_data_in), 32'(e.data));
                    end
                end
            end
        end
    end

    // Done model: answers each Start 10 cycles later and queues the 64 expected words.
    initial begin
        doneModel = 1'b0;
        forever begin
            @(negedge ACLK);
            if (Start === 1'b1) begin
                startCount++;
                repeat (10) @(posedge ACLK);
                #1 doneModel = 1'b1;
                for (int k = 0; k < RES_WORDS; k++) begin
                    expQ.push_back('{data: resRam[k], last: (k == RES_WORDS - 1), idx: 7'(k)});
                end
                @(posedge ACLK);
                #1 doneModel = 1'b0;
                @(negedge ACLK);
                checkOutput("read_en cycle after Done", 32'(RES_read_en), 32'd1);
                @(negedge ACLK);
                checkOutput("TVALID 2 cycles after Done", 32'(M_AXIS_TVALID), 32'd1);
            end
        end
    end

    // Master-stream monitor: compares each handshake and checks stall stability.
    initial begin
        out_t        e;
        bit          stallPrev;
        logic [31:0] prevData;
        logic        prevLast;
        int          lastHsCyc;
        stallPrev = 0;
        prevData  = '0;
        prevLast  = 1'b0;
        lastHsCyc = 0;
        forever begin
            @(negedge ACLK);
            if (M_AXIS_TVALID === 1'b1) begin
                if (stallPrev) begin
                    checkOutput("TDATA stable in stall", M_AXIS_TDATA, prevData);
                    checkOutput("TLAST stable in stall", 32'(M_AXIS_TLAST), 32'(prevLast));
                end
                if (M_AXIS_TREADY) begin
                    stallPrev = 0;
                    if (expQ.size() == 0) begin
                        failNow("unexpected output word");
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("output data", M_AXIS_TDATA, 32'(e.data));
                        checkOutput("output TLAST", 32'(M_AXIS_TLAST), 32'(e.last));
                        if (checkConsec && e.idx != 7'd0) begin
                            checkOutput("back-to-back output", 32'(cyc), 32'(lastHsCyc + 1));
                        end
                    end
                    lastHsCyc = cyc;
                    wordsOut++;
                end else begin
                    stallPrev = 1;
                    prevData  = M_AXIS_TDATA;
                    prevLast  = M_AXIS_TLAST;
                end
            end else begin
                if (stallPrev && !rstFlag) failNow("TVALID dropped without handshake");
                stallPrev = 0;
            end
        end
    end

    // Presents one input word and records the write it must cause.
    task automatic applyStimulus(input int idx, input logic [31:0] data,
                                 input bit last, input bit expectWrite);
        S_AXIS_TDATA  = data;
        S_AXIS_TLAST  = last;
        S_AXIS_TVALID = 1'b1;
        @(negedge ACLK);
        checkOutput("S_AXIS_TREADY while loading", 32'(S_AXIS_TREADY), 32'd1);
        checkOutput("no Start before last word", 32'(Start), 32'd0);
        if (expectWrite) begin
            wrQ.push_back('{isA: (idx < A_WORDS),
                            addr: AW'((idx < A_WORDS) ? idx : idx - A_WORDS),
                            data: data[W-1:0]});
        end
        @(posedge ACLK);
        #1;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    // gapMode: 0 back-to-back, 1 idle cycle before every word, 2 random idles.
    task automatic runFrame(input int gapMode, input bit spurious,
                            input bit randTlast, input int rdyMode);
        int gap;
        bit last;
        readyMode   = rdyMode;
        checkConsec = (rdyMode == 0);
        for (int i = 0; i < IN_WORDS; i++) begin
            gap = (gapMode == 0) ? 0 : (gapMode == 1) ? 1 : int'($urandom_range(0, 2));
            repeat (gap) begin
                @(posedge ACLK);
                #1;
            end
            if (spurious && i == 100) begin
                doneSpur = 1'b1;
                @(posedge ACLK);
                #1 doneSpur = 1'b0;
                @(negedge ACLK);
                checkOutput("spurious Done: no read_en", 32'(RES_read_en), 32'd0);
                checkOutput("spurious Done: still loading", 32'(S_AXIS_TREADY), 32'd1);
                @(posedge ACLK);
                #1;
            end
            last = (i == IN_WORDS - 1) ? 1'b1 : (randTlast ? 1'($urandom_range(0, 1)) : 1'b0);
            applyStimulus(i, $urandom, last, 1'b1);
        end
        @(negedge ACLK);
        checkOutput("Start after last word", 32'(Start), 32'd1);
        @(negedge ACLK);
        checkOutput("Start is one cycle", 32'(Start), 32'd0);
    endtask

    // Waits (bounded) until the monitor has seen `target` words; returns on the
    // clock edge that completed the last of them.
    task automatic waitOutputs(input int target);
        for (int c = 0; c < 4000; c++) begin
            @(posedge ACLK);
            if (wordsOut >= target) break;
        end
        if (wordsOut < target) failNow("timeout waiting for output words");
    endtask

    task automatic checkFrameEnd();
        @(negedge ACLK);
        checkOutput("TVALID low after last word", 32'(M_AXIS_TVALID), 32'd0);
        checkOutput("S_AXIS_TREADY back after last word", 32'(S_AXIS_TREADY), 32'd1);
        checkOutput("write queue drained", 32'(wrQ.size()), 32'd0);
        checkOutput("output queue drained", 32'(expQ.size()), 32'd0);
        @(posedge ACLK);
        #1;
    endtask

    task automatic fillResRam(input bit ramp);
        for (int k = 0; k < RES_WORDS; k++) begin
            resRam[k] = ramp ? W'(k + 3) : W'($urandom);
        end
    endtask

    initial begin
        int base;
        int expStarts;
        bit randTl;
        expStarts     = 0;
        ARESET        = 1'b1;
        S_AXIS_TDATA  = '0;
        S_AXIS_TLAST  = 1'b0;
        S_AXIS_TVALID = 1'b0;
        doneSpur      = 1'b0;
`ifdef INPUT_TLAST_CHECK_EN
        randTl = 1'b0;
`else
        randTl = 1'b1;
`endif
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        checkOutput("reset S_AXIS_TREADY", 32'(S_AXIS_TREADY), 32'd1);
        checkOutput("reset M_AXIS_TVALID", 32'(M_AXIS_TVALID), 32'd0);
        checkOutput("reset M_AXIS_TDATA", M_AXIS_TDATA, 32'd0);
        checkOutput("reset M_AXIS_TLAST", 32'(M_AXIS_TLAST), 32'd0);
        checkOutput("reset Start", 32'(Start), 32'd0);
        checkOutput("reset A_write_en", 32'(A_write_en), 32'd0);
        checkOutput("reset B_write_en", 32'(B_write_en), 32'd0);
        checkOutput("reset A_write_address", 32'(A_write_address), 32'd0);
        checkOutput("reset RES_read_en", 32'(RES_read_en), 32'd0);
        checkOutput("reset Protocol_error", 32'(Protocol_error), 32'd0);
        @(posedge ACLK);
        #1 ARESET = 1'b0;

        $display("[TB] full frame, back-to-back, ramp results");
        fillResRam(1'b1);
        base = wordsOut;
        runFrame(0, 1'b0, 1'b0, 0);
        expStarts++;
        waitOutputs(base + RES_WORDS);
        checkFrameEnd();
        checkOutput("one Start per frame", 32'(startCount), 32'(expStarts));

        $display("[TB] throttled input, spurious Done, random TREADY");
        fillResRam(1'b0);
        base = wordsOut;
        runFrame(1, 1'b1, randTl, 2);
        expStarts++;
        waitOutputs(base + RES_WORDS);
        checkFrameEnd();

        $display("[TB] random input gaps, patterned backpressure");
        fillResRam(1'b0);
        base = wordsOut;
        runFrame(2, 1'b0, randTl, 1);
        expStarts++;
        waitOutputs(base + RES_WORDS);
        checkFrameEnd();

        $display("[TB] reset during output");
        fillResRam(1'b0);
        base = wordsOut;
        runFrame(0, 1'b0, 1'b0, 0);
        expStarts++;
        waitOutputs(base + 21);
        rstFlag = 1;
        #1 ARESET = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        checkOutput("reset mid-output TVALID", 32'(M_AXIS_TVALID), 32'd0);
        checkOutput("reset mid-output S_AXIS_TREADY", 32'(S_AXIS_TREADY), 32'd1);
        checkOutput("reset mid-output read_en", 32'(RES_read_en), 32'd0);
        ARESET = 1'b0;
        expQ.delete();
        @(posedge ACLK);
        #1 rstFlag = 0;

        $display("[TB] fresh frame after reset");
        fillResRam(1'b0);
        base = wordsOut;
        runFrame(0, 1'b0, 1'b0, 0);
        expStarts++;
        waitOutputs(base + RES_WORDS);
        checkFrameEnd();

`ifdef INPUT_TLAST_CHECK_EN
        $display("[TB] early TLAST on word 100");
        ignoreWrites = 1;
        for (int i = 0; i <= 100; i++) begin
            applyStimulus(i, $urandom, (i == 100), 1'b0);
        end
        @(negedge ACLK);
        checkOutput("Protocol_error after early TLAST", 32'(Protocol_error), 32'd1);
        repeat (20) @(negedge ACLK);
        checkOutput("no Start after bad frame", 32'(startCount), 32'(expStarts));
        checkOutput("still loading after bad frame", 32'(S_AXIS_TREADY), 32'd1);
        ignoreWrites = 0;
        @(posedge ACLK);
        #1;
        fillResRam(1'b0);
        base = wordsOut;
        runFrame(0, 1'b0, 1'b0, 0);
        expStarts++;
        waitOutputs(base + RES_WORDS);
        checkFrameEnd();
        checkOutput("Protocol_error sticky", 32'(Protocol_error), 32'd1);
`else
        checkOutput("Protocol_error tied low", 32'(Protocol_error), 32'd0);
`endif

        checkOutput("total Start pulses", 32'(startCount), 32'(expStarts));
        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axis_mm_controller.md
# axis_mm_controller

Top-level sequencer for the AXI-Stream matrix-multiply coprocessor. It does three jobs in turn:
- Accepts the A and B operand words on an AXI4-Stream slave and writes them into A_RAM and B_RAM.
- Pulses Start to matrix_multiply and waits for its Done pulse.
- Streams the RES_RAM contents out on an AXI4-Stream master.

It sits between the DMA-facing stream ports and the matrix_multiply/RAM cluster.

## Interface
- width, 8: data bits per RAM word.
- A_depth_bits, 9: A_RAM address bits (A words = 2^A_depth_bits = 512).
- B_depth_bits, 3: B_RAM address bits (B words = 8).
- RES_depth_bits, 6: RES_RAM address bits (result words = 64).

Ports:
- ACLK  in  1  single clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AXIS_TREADY  out  1  slave ready.
- S_AXIS_TDATA  in  32  input word; only bits [width-1:0] are used.
- S_AXIS_TLAST  in  1  last input word marker.
- S_AXIS_TVALID  in  1  slave valid.
- M_AXIS_TVALID  out  1  master valid.
- M_AXIS_TDATA  out  32  result word, zero-extended from width bits.
- M_AXIS_TLAST  out  1  asserted with the final result word.
- M_AXIS_TREADY  in  1  master ready.
- A_write_en / A_write_address / A_write_data_in  out  1 / A_depth_bits / width  A_RAM write port.
- B_write_en / B_write_address / B_write_data_in  out  1 / B_depth_bits / width  B_RAM write port.
- Start  out  1  one-cycle pulse to matrix_multiply.
- Done  in  1  one-cycle pulse from matrix_multiply.
- RES_read_en / RES_read_address  out  1 / RES_depth_bits  RES_RAM synchronous read port.
- RES_read_data_out  in  width  RES_RAM read data, valid 1 cycle after read_en.
- Protocol_error  out  1  sticky TLAST-mismatch flag (see Configuration).

## Operation
- The FSM has three states: READ_INPUTS (reset state), COMPUTE, WRITE_OUTPUTS.
- **READ_INPUTS:**
  - S_AXIS_TREADY=1.
  - Each handshake (TVALID&&TREADY) with input counter i does the following:
    - i < 512: A_write_en=1, A_write_address=i.
    - Otherwise: B_write_en=1, B_write_address=i-512.
    - data_in = TDATA[width-1:0].
  - The write signals are registered and assert the cycle after the handshake, for exactly one cycle.
  - The handshake on word 519 (the last word) moves the FSM to COMPUTE; the counter clears.
- **COMPUTE:**
  - S_AXIS_TREADY=0.
  - Start=1 for exactly the first cycle in COMPUTE.
  - The block then waits indefinitely for Done=1. Done moves the FSM to WRITE_OUTPUTS.
  - Done in any other state is ignored.
- **WRITE_OUTPUTS:**
  - RES_RAM addresses 0..63 are read in order and presented on M_AXIS.
  - Words are prefetched through a 2-entry output buffer, so throughput is 1 word/cycle while TREADY=1.
  - RES_read_en is asserted only when a buffer slot will be free when the data returns. No word is dropped or duplicated under any TREADY pattern.
  - M_AXIS_TLAST=1 only on word 63.
  - The handshake on word 63 returns the FSM to READ_INPUTS.
- The RAM contents are never cleared by this block.

## Timing
- **Reset values (cycle after ARESET sampled high):**
  - State = READ_INPUTS; all counters 0.
  - All outputs 0, except S_AXIS_TREADY=1.
- **Reset mid-operation:** reset overrides everything in any state. Any in-flight stream transfer is abandoned, and no Start or write pulse is issued that cycle.
- **Input side:**
  - The write-port latency is 1 cycle after the handshake.
  - Back-to-back handshakes give back-to-back writes.
  - TVALID gaps pause the counter.
- **Start:** asserts the cycle after the final input handshake.
- **Done→output:**
  - RES_read_en asserts the cycle after Done is sampled.
  - M_AXIS_TVALID first asserts 2 cycles after Done is sampled.
- **Output stability:** while TVALID=1 and TREADY=0, TDATA, TLAST and TVALID hold stable.
- **Output sequencing:**
  - TVALID never deasserts without a handshake.
  - TVALID deasserts the cycle after the word-63 handshake.
  - S_AXIS_TREADY returns to 1 in that same cycle.
- **Simultaneous events:** Done arriving in the same cycle as Start is impossible by construction, because Start and Done are one cycle apart minimum. If it happens anyway, Done is ignored in the Start cycle.

## Configuration
- **INPUT_TLAST_CHECK_EN defined:** the block sets Protocol_error=1 (sticky until ARESET) in either case below:
  - S_AXIS_TLAST=1 on a handshake with i < 519.
  - S_AXIS_TLAST=0 on word 519.

  In both cases:
  - The input counter resets to 0 and the FSM stays in READ_INPUTS (the frame is discarded; no Start).
  - A premature TLAST is the error word itself.
- **Undefined:**
  - S_AXIS_TLAST is ignored.
  - Frames are delimited purely by count.
  - Protocol_error is tied to 0.

## Test plan
- **Full frame:**
  - Stimulus:
    - Stream 512 A words, then 8 B words, back-to-back, TLAST on the last word.
    - Done model responds 10 cycles after Start; RES_RAM preloaded with addr k = k+3.
    - M_AXIS_TREADY=1.
  - Required response:
    - A written at 0..511 and B written at 0..7.
    - One Start pulse.
    - 64 outputs 0x03..0x42 on consecutive cycles, TLAST only on the 64th.
- **Input throttling:** TVALID toggled every other cycle -> writes only on handshake cycles, addresses contiguous, Start only after word 519.
- **Output backpressure:** TREADY pattern 1,0,0,1,0,1... -> every word 0..63 exactly once, in order, TDATA stable across stall cycles.
- **Reset mid-output:** ARESET asserted after word 20 -> next cycle TVALID=0, S_AXIS_TREADY=1; a fresh full frame then completes normally with outputs from address 0.
- **Spurious Done:** Done pulsed during READ_INPUTS -> no state change, no RES_read_en.
- **Early TLAST (macro defined):** TLAST on word 100 -> Protocol_error=1, no Start, the next 520-word frame is processed normally, Protocol_error stays 1.
